// File: rtl/cu_definitions_pkg.sv
// Shared control-unit definitions for the trig sequencer and its CORDIC datapath.
package cu_definitions_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } trig_state_t;

  // Gain pre-load for the datapath x accumulator, 0.607253 in Q2.30
  localparam logic [31:0] CORDIC_K      = 32'h26DD3B6A;
  localparam logic        TRIG_SIN      = 1'b0;
  localparam logic        TRIG_COS      = 1'b1;
  localparam logic [1:0]  TRIG_MEMTOREG = 2'b11;

endpackage

// File: rtl/trig_sequencer.sv
// Multi-cycle SIN/COS sequencer: stalls the front-end, steps the CORDIC datapath,
// and hands the selected accumulator back to writeback with its destination tag.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; accept captures sel/dest/angle
// LOAD    | datapath seeds x=K, y=0, z=angle_q
// ITER    | one micro-rotation per cycle, index 0..ITERATIONS-1
// DONE    | result_valid strobe; pipeline released this cycle
module trig_sequencer
  import cu_definitions_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ITERATIONS = 16,
  parameter int ITER_W     = $clog2(ITERATIONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              trig_sel,
  input  logic [DATA_W-1:0] angle,
  input  logic [3:0]        dest_reg,
  input  logic              abort,
  input  logic [DATA_W-1:0] cordic_x,
  input  logic [DATA_W-1:0] cordic_y,
  output logic              stall,
  output logic              busy,
  output logic              cordic_load,
  output logic [DATA_W-1:0] angle_q,
  output logic              iter_en,
  output logic [ITER_W-1:0] iter_idx,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        result_reg,
  output logic              result_valid
);

  localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(ITERATIONS - 1);

  trig_state_t       state_q, state_d;
  logic [ITER_W-1:0] cnt_q;
  logic              sel_q;
  logic [3:0]        dest_q;
  logic              accept;
  logic              last_iter;

  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign last_iter = (state_q == ST_ITER) && (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = abort ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // stall is gated by rst_n so a held start cannot stall the pipe during reset
  always_comb begin
    cordic_load  = (state_q == ST_LOAD);
    iter_en      = (state_q == ST_ITER);
    busy         = (state_q == ST_LOAD) || (state_q == ST_ITER);
    result_valid = (state_q == ST_DONE);
    stall        = rst_n && (accept || busy);
  end

  assign iter_idx = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sel_q      <= TRIG_SIN;
      dest_q     <= '0;
      angle_q    <= '0;
      result     <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        sel_q   <= trig_sel;
        dest_q  <= dest_reg;
        angle_q <= angle;
      end
      // Counter is nonzero only inside ITER, so iter_idx idles at 0.
      if ((state_q == ST_ITER) && !abort && !last_iter) cnt_q <= cnt_q + 1'b1;
      else                                              cnt_q <= '0;
      if (last_iter && !abort) begin
        result     <= (sel_q == TRIG_COS) ? cordic_x : cordic_y;
        result_reg <= dest_q;
      end
    end
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed and randomized checks of trig_sequencer against a cycle-offset reference model.
module tb_trig_sequencer;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, trig_sel, abort;
  logic [31:0] angle, cordic_x, cordic_y;
  logic [3:0]  dest_reg;
  logic        stall, busy, cordic_load, iter_en, result_valid;
  logic [31:0] angle_q, result;
  logic [3:0]  iter_idx, result_reg;

  trig_sequencer #(.DATA_W(32), .ITERATIONS(N), .ITER_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trig_sel(trig_sel), .angle(angle),
    .dest_reg(dest_reg), .abort(abort), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .stall(stall), .busy(busy), .cordic_load(cordic_load), .angle_q(angle_q),
    .iter_en(iter_en), .iter_idx(iter_idx), .result(result), .result_reg(result_reg),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Model: off = cycles since accept (0 = no op in flight this cycle).
  int          off;
  logic        m_sel;
  logic [3:0]  m_dest, m_resreg;
  logic [31:0] m_angle, m_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit acc, act, itr;
    acc = (off == 0) && start && !abort && rst_n;
    act = (off >= 1) && (off <= N + 1);
    itr = (off >= 2) && (off <= N + 1);
    chk("stall", stall, acc || act);
    chk("busy", busy, act);
    chk("cordic_load", cordic_load, off == 1);
    chk("iter_en", iter_en, itr);
    chk("iter_idx", iter_idx, itr ? off - 2 : 0);
    chk("result_valid", result_valid, off == N + 2);
    chk("angle_q", angle_q, m_angle);
    chk("result", result, m_res);
    chk("result_reg", result_reg, m_resreg);
    if (result_valid === 1'b1) pulses++;
  endtask

  task automatic model_next();
    if (!rst_n) begin
      off = 0; m_sel = 0; m_dest = 0; m_angle = 0; m_res = 0; m_resreg = 0;
    end else if (off == 0) begin
      if (start && !abort) begin
        off = 1; m_sel = trig_sel; m_dest = dest_reg; m_angle = angle;
      end
    end else if (off <= N + 1 && abort) begin
      off = 0;
    end else if (off == N + 1) begin
      m_res = m_sel ? cordic_x : cordic_y;
      m_resreg = m_dest;
      off = N + 2;
    end else if (off == N + 2) begin
      off = 0;
    end else begin
      off++;
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    model_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 0; start = 1; abort = 0; trig_sel = 0;
    angle = 32'h3243F6A8; dest_reg = 4'd5;
    cordic_x = 32'h0; cordic_y = 32'h2D413CCD;
    model_next();
    @(posedge clk); #1;
    repeat (3) tick();

    // release reset, no start: nothing happens
    start = 0; rst_n = 1;
    repeat (2) tick();

    // SIN of pi/4
    start = 1; pulses = 0;
    repeat (N + 3) tick();
    start = 0; tick();
    chk("sin_pulses", pulses, 1);
    chk("sin_result", result, 32'h2D413CCD);
    chk("sin_dest", result_reg, 4'd5);

    // COS
    trig_sel = 1; dest_reg = 4'd9; cordic_x = 32'h2D413CCD; cordic_y = 32'h0;
    start = 1; pulses = 0;
    repeat (N + 3) tick();
    start = 0; tick();
    chk("cos_pulses", pulses, 1);
    chk("cos_result", result, 32'h2D413CCD);
    chk("cos_dest", result_reg, 4'd9);

    // abort at iter_idx 7
    trig_sel = 0; dest_reg = 4'd3; cordic_y = 32'h11112222;
    start = 1; pulses = 0; guard = 0;
    while (off != 9 && guard < 40) begin tick(); guard++; end
    chk("abort_wait", guard < 40, 1'b1);
    abort = 1; tick();
    abort = 0; start = 0; tick();
    repeat (N + 4) tick();
    chk("abort_pulses", pulses, 0);
    chk("abort_result", result, 32'h2D413CCD);
    chk("abort_dest", result_reg, 4'd9);

    // back-to-back with start held through DONE
    dest_reg = 4'd12; start = 1; pulses = 0;
    repeat (2 * N + 6) tick();
    start = 0; repeat (2) tick();
    chk("b2b_pulses", pulses, 2);

    // async reset mid-ITER at iter_idx 4
    start = 1; guard = 0;
    while (off != 6 && guard < 40) begin tick(); guard++; end
    chk("rst_wait", guard < 40, 1'b1);
    #1 chk("pre_rst_idx", iter_idx, 4);
    #1 rst_n = 0;
    #1;
    chk("arst_stall", stall, 1'b0);
    chk("arst_iter_en", iter_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    model_next();
    start = 0;
    @(posedge clk); #1;
    tick();
    rst_n = 1; tick();
    start = 1; pulses = 0;
    repeat (N + 3) tick();
    start = 0; tick();
    chk("post_rst_pulses", pulses, 1);
    chk("post_rst_result", result, m_sel ? cordic_x : cordic_y);

    // randomized traffic; datapath stub only changes between ops
    repeat (500) begin
      if (off == 0) begin
        cordic_x = $urandom;
        cordic_y = $urandom;
      end
      start    = ($urandom_range(0, 3) != 0);
      trig_sel = $urandom_range(0, 1);
      angle    = $urandom;
      dest_reg = 4'($urandom_range(0, 15));
      abort    = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trig_sequencer.md
# trig_sequencer

Multi-cycle controller for the iterative CORDIC trig datapath that serves SIN/COS instructions (memToReg = 2'b11, trigControl selects sin/cos). It sits beside the EX stage. When EX presents a trig op, it stalls the pipeline front-end and sequences the load and iteration steps of the sibling CORDIC datapath. It then returns the selected result, tagged with its destination register, to the writeback path.

## Interface
- DATA_W, 32, datapath width; angles and results in signed Q2.30
- ITERATIONS, 16, CORDIC micro-rotations per op (>= 2)
- ITER_W, $clog2(ITERATIONS), iteration index width
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EX holds a valid SIN/COS op (held while stalled)
- trig_sel  in  1  0 = SIN, 1 = COS (trigControl)
- angle  in  DATA_W  operand, valid with start
- dest_reg  in  4  destination register of the op
- abort  in  1  kill in-flight op (pipeline flush)
- cordic_x, cordic_y  in  DATA_W  datapath cosine/sine accumulators
- stall  out  1  freeze IF/ID/EX
- busy  out  1  op in flight (LOAD or ITER)
- cordic_load  out  1  datapath loads x=K, y=0, z=angle_q
- angle_q  out  DATA_W  angle captured at accept
- iter_en  out  1  datapath performs one micro-rotation
- iter_idx  out  ITER_W  current rotation index (shift amount / atan LUT address)
- result  out  DATA_W  last completed result
- result_reg  out  4  destination of result
- result_valid  out  1  one-cycle writeback strobe

## Operation
- FSM states: IDLE, LOAD, ITER, DONE (enum in package).
- IDLE: `start && !abort` → capture trig_sel, dest_reg, angle → LOAD. Otherwise stay in IDLE.
- LOAD: cordic_load=1 for exactly one cycle; clear iteration counter → ITER.
- ITER: iter_en=1, iter_idx = counter, counter increments each cycle. When iter_idx == ITERATIONS-1, next state is DONE.
- DONE: result_valid=1. result ← cordic_y (SIN) or cordic_x (COS). result_reg ← captured dest. Next state IDLE unconditionally.
- stall = (IDLE && start && !abort) || LOAD || ITER. This is combinational on start only in IDLE; otherwise decoded from state.
- busy = LOAD || ITER.
- start is ignored in LOAD/ITER/DONE. In DONE, start is still high for the retiring op and must not retrigger.
- abort in LOAD or ITER → IDLE next cycle. No result_valid; result/result_reg unchanged; stall stays asserted in the abort cycle. abort in DONE has no effect (writeback proceeds).
- K constant (0x26DD3B6A, 0.607253 in Q2.30) is applied by the datapath on cordic_load. This block does no arithmetic.
- Angle range: |angle| <= π/2 (0x6487ED51). Out-of-range input is not reduced. Result is undefined but sequencing is unaffected.

## Timing
- Reset values: state IDLE, counter 0, stall 0, busy 0, cordic_load 0, iter_en 0, iter_idx 0, angle_q 0, result 0, result_reg 0, result_valid 0.
- rst_n low mid-op forces all of the above immediately, with no result.
- Accept at cycle T. Then:
  - cordic_load at T+1.
  - iter_idx 0..ITERATIONS-1 across T+2..T+ITERATIONS+1.
  - result_valid and registered result at T+ITERATIONS+2.
  - stall low at T+ITERATIONS+2; the pipeline advances at the end of that cycle.
- Latency: ITERATIONS+2 cycles (18 at default).
- Back-to-back ops: a new start is accepted the cycle after DONE (T+ITERATIONS+3).
- Outputs other than stall are registered or state-decoded; no combinational path from data inputs.

## Structure
- Package `cu_definitions_pkg`:
  - trig_state_t enum
  - CORDIC_K constant
  - TRIG_SIN/TRIG_COS trig_sel encodings
  - TRIG_MEMTOREG = 2'b11
- Single module holds the FSM and iteration counter; no sub-module.
- The atan LUT and shift-add datapath live in the sibling cordic_datapath, which is driven by cordic_load/iter_en/iter_idx.

## Test plan
- Reset: hold rst_n=0 with start=1 → every output 0. Release → no activity until the next rising edge with start.
- SIN: angle=0x3243F6A8 (π/4), dest_reg=5, stubbed cordic_y=0x2D413CCD → stall high T..T+17, cordic_load T+1, iter_idx 0..15 at T+2..T+17, result_valid T+18 with result=0x2D413CCD, result_reg=5.
- COS: trig_sel=1, dest_reg=9, stub cordic_x=0x2D413CCD, cordic_y=0 → result=0x2D413CCD, result_reg=9, exactly one result_valid pulse.
- Abort: pulse abort when iter_idx=7 → IDLE next cycle, stall low, no result_valid, result keeps its previous value.
- Back-to-back: start held through DONE, then a second op at T+19 → exactly two result_valid pulses (T+18, T+37), no retrigger at T+18.
- Async reset mid-ITER: drop rst_n at iter_idx=4 off-edge → stall/iter_en/busy fall without waiting for clk; a later op completes normally.
